ps2_kbd_rx: RTL
===============

Name: ps2_kbd_rx

Overview:
- Receives raw PS/2 keyboard frames on the ps2_clk/ps2_data pins and checks start, parity and stop bits.
- Strips the E0 (extended) and F0 (break) prefix bytes and emits one decoded key event per make or break code.
- Sits directly upstream of the keyboard I/O / key-matrix stage: code_valid together with scan_code, is_break and is_extended let that stage set and clear matrix bits explicitly instead of toggling them.

Parameters:
- CLK_HZ, 27000000, system clock frequency in Hz.
- FILTER_LEN, 8, number of consecutive identical synchronized samples required before the filtered ps2_clk changes state.
- TIMEOUT_US, 200, maximum gap between ps2_clk falling edges inside a frame before the frame is aborted; TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US (5400 at the defaults).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  reset; asynchronous, active-low.
- ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data, asynchronous to clk.
- scan_code  output  8  decoded scan code; held stable until the next event.
- code_valid  output  1  one-cycle pulse; scan_code, is_break and is_extended are valid in that cycle.
- is_break  output  1  event is a key release (F0 prefix was seen).
- is_extended  output  1  event carried the E0 prefix.
- frame_error  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. On reset, all outputs are 0, the FSM is in IDLE, the shift register, bit counter, timeout counter and prefix flags are cleared, and the filtered clock is 1.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-FF synchronizer. Filtered clock changes only after FILTER_LEN equal samples of the synchronized clock. A falling edge of the filtered clock is the sampling strobe; ps2_data (synchronized) is sampled in that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a strobe, if data = 0 go to DATA with bit count 0; if data = 1 it is a false start, stay in IDLE and do not pulse frame_error.
  - DATA: on each strobe, shift data in LSB-first. After the 8th bit go to PARITY.
  - PARITY: on a strobe, store the parity bit. Parity is odd: the XOR of the 8 data bits and the parity bit must be 1. Go to STOP.
  - STOP: on a strobe, require data = 1 and a parity pass, then run byte processing; otherwise pulse frame_error. In both cases return to IDLE.
- Timeout: the counter resets on every strobe and counts only outside IDLE. When it reaches TIMEOUT_CYC-1, pulse frame_error, clear the prefix flags and go to IDLE; the partial byte is discarded.
- Byte processing, registered; code_valid asserts 1 cycle after the STOP strobe:
  - 0xE0: set ext_flag; no event.
  - 0xF0: set brk_flag; no event.
  - Any other byte: scan_code = byte, is_extended = ext_flag, is_break = brk_flag, code_valid = 1 for one cycle; then clear both flags.
  - E1, AA and FA are not special-cased and are emitted as ordinary codes.
- Any frame error clears both prefix flags. Error and valid are mutually exclusive in a cycle.
- is_break and is_extended hold their values with scan_code between events.
- A strobe arriving in the same cycle as the timeout expiry: the timeout wins and the strobe is ignored.
- Throughput is bounded by the PS/2 line rate (at least 60 us per bit), so no back-pressure is required; consumers must accept code_valid on every pulse.
- Host-to-device transmission is not supported; ps2_clk and ps2_data are inputs only.

Test Plan:
- Frame 0x1C with parity 0 and stop 1 at 12.5 kHz -> one code_valid pulse with scan_code = 0x1C, is_break = 0, is_extended = 0; frame_error stays 0.
- Frames F0 then 1C -> exactly one event: scan_code = 0x1C, is_break = 1, is_extended = 0; no event after the F0 frame.
- Frames E0, F0, 75 -> one event: scan_code = 0x75, is_break = 1, is_extended = 1; the following frame 0x29 -> is_break = 0, is_extended = 0.
- Frame 0x1C with parity 1 -> frame_error pulse, no code_valid. Frames F0 (good) then 1C with bad parity, then 1C (good) -> is_break = 0, since the error cleared the flag.
- Stop after 4 data bits for 300 us -> frame_error pulse at 5400 cycles after the last edge; the next good 0x2D frame -> scan_code = 0x2D.
- Assert reset_n low mid-frame after 5 bits, release it, send 0x16 -> outputs are 0 during reset; after release exactly one event with scan_code = 0x16; 2-cycle glitches on ps2_clk produce no strobes.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: conditions the raw pins, checks each 11-bit frame and
// folds E0/F0 prefix bytes into one registered key event per make or break code.
`timescale 1ns/1ps
module ps2_kbd_rx #(
   parameter int CLK_HZ     = 27000000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 200
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       code_valid,
   output logic       is_break,
   output logic       is_extended,
   output logic       frame_error
);

   localparam int TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
   localparam int TMO_W       = $clog2(TIMEOUT_CYC);
   localparam int FLT_W       = $clog2(FILTER_LEN + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t           state_q, state_d;
   logic             ps2_clk_meta_q, ps2_clk_sync_q;
   logic             ps2_data_meta_q, ps2_data_sync_q;
   logic             clk_filt_q, clk_filt_d;
   logic             clk_prev_q, clk_prev_d;
   logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             parity_q, parity_d;
   logic             ext_flag_q, ext_flag_d;
   logic             brk_flag_q, brk_flag_d;
   logic [7:0]       scan_code_q, scan_code_d;
   logic             code_valid_q, code_valid_d;
   logic             is_break_q, is_break_d;
   logic             is_extended_q, is_extended_d;
   logic             frame_error_q, frame_error_d;
   logic             strobe;
   logic             timeout_hit;

   // Idle PS/2 lines are high, so the synchronizers come out of reset at 1 too.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ps2_clk_meta_q  <= 1'b1;
         ps2_clk_sync_q  <= 1'b1;
         ps2_data_meta_q <= 1'b1;
         ps2_data_sync_q <= 1'b1;
         state_q         <= IDLE;
         clk_filt_q      <= 1'b1;
         clk_prev_q      <= 1'b1;
         flt_cnt_q       <= '0;
         tmo_cnt_q       <= '0;
         bit_cnt_q       <= '0;
         shift_q         <= '0;
         parity_q        <= 1'b0;
         ext_flag_q      <= 1'b0;
         brk_flag_q      <= 1'b0;
         scan_code_q     <= '0;
         code_valid_q    <= 1'b0;
         is_break_q      <= 1'b0;
         is_extended_q   <= 1'b0;
         frame_error_q   <= 1'b0;
      end else begin
         ps2_clk_meta_q  <= ps2_clk;
         ps2_clk_sync_q  <= ps2_clk_meta_q;
         ps2_data_meta_q <= ps2_data;
         ps2_data_sync_q <= ps2_data_meta_q;
         state_q         <= state_d;
         clk_filt_q      <= clk_filt_d;
         clk_prev_q      <= clk_prev_d;
         flt_cnt_q       <= flt_cnt_d;
         tmo_cnt_q       <= tmo_cnt_d;
         bit_cnt_q       <= bit_cnt_d;
         shift_q         <= shift_d;
         parity_q        <= parity_d;
         ext_flag_q      <= ext_flag_d;
         brk_flag_q      <= brk_flag_d;
         scan_code_q     <= scan_code_d;
         code_valid_q    <= code_valid_d;
         is_break_q      <= is_break_d;
         is_extended_q   <= is_extended_d;
         frame_error_q   <= frame_error_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      clk_filt_d    = clk_filt_q;
      clk_prev_d    = clk_filt_q;
      flt_cnt_d     = '0;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      parity_d      = parity_q;
      ext_flag_d    = ext_flag_q;
      brk_flag_d    = brk_flag_q;
      scan_code_d   = scan_code_q;
      is_break_d    = is_break_q;
      is_extended_d = is_extended_q;
      code_valid_d  = 1'b0;
      frame_error_d = 1'b0;

      // The filtered clock flips only after FILTER_LEN disagreeing samples in a row.
      if (ps2_clk_sync_q != clk_filt_q) begin
         if (flt_cnt_q == FLT_LAST) begin
            clk_filt_d = ps2_clk_sync_q;
         end else begin
            flt_cnt_d = flt_cnt_q + FLT_W'(1);
         end
      end

      strobe      = clk_prev_q & ~clk_filt_q;
      timeout_hit = (state_q != IDLE) && (tmo_cnt_q == TMO_LAST);

      if ((state_q == IDLE) || strobe) begin
         tmo_cnt_d = '0;
      end else begin
         tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end

      // Timeout takes priority over a coincident strobe.
      if (timeout_hit) begin
         frame_error_d = 1'b1;
         ext_flag_d    = 1'b0;
         brk_flag_d    = 1'b0;
         state_d       = IDLE;
         bit_cnt_d     = '0;
         shift_d       = '0;
         tmo_cnt_d     = '0;
      end else if (strobe) begin
         case (state_q)
            IDLE: begin
               if (!ps2_data_sync_q) begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
            DATA: begin
               shift_d   = {ps2_data_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end
            end
            PARITY: begin
               parity_d = ps2_data_sync_q;
               state_d  = STOP;
            end
            STOP: begin
               state_d = IDLE;
               if (ps2_data_sync_q && (^{shift_q, parity_q})) begin
                  if (shift_q == 8'hE0) begin
                     ext_flag_d = 1'b1;
                  end else if (shift_q == 8'hF0) begin
                     brk_flag_d = 1'b1;
                  end else begin
                     scan_code_d   = shift_q;
                     is_break_d    = brk_flag_q;
                     is_extended_d = ext_flag_q;
                     code_valid_d  = 1'b1;
                     ext_flag_d    = 1'b0;
                     brk_flag_d    = 1'b0;
                  end
               end else begin
                  frame_error_d = 1'b1;
                  ext_flag_d    = 1'b0;
                  brk_flag_d    = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign scan_code   = scan_code_q;
   assign code_valid  = code_valid_q;
   assign is_break    = is_break_q;
   assign is_extended = is_extended_q;
   assign frame_error = frame_error_q;

endmodule
